// File: rtl/aes_pkg.sv
// Shared AES constants, scheduler FSM state type and GF(2^8) helpers.
// Pure declarations and combinational functions; no state.
// No handshake of its own.
package aes_pkg;

  localparam int         AES_STATE_W = 128;
  localparam int         AES_COL_W   = 32;
  localparam logic [7:0] AES_POLY    = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply x by coefficient c via shift-and-xor over the bits of c.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = x;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// Single-column MixColumns (InvMixColumns too when AES_MIXCOL_INV_EN is defined).
// Purely combinational, zero latency.
// No handshake; the scheduler owns all flow control.
module aes_mixcol_col
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
`ifdef AES_MIXCOL_INV_EN
  input  logic                 inv,
`endif
  output logic [AES_COL_W-1:0] col_o
);

  // First matrix row; later rows are the same bytes rotated right by the row index.
  logic [AES_COL_W-1:0] coef_row;

  // Select forward or inverse circulant coefficients.
  always_comb begin
    coef_row = 32'h02030101;
`ifdef AES_MIXCOL_INV_EN
    if (inv) coef_row = 32'h0e0b0d09;
`endif
  end

  // b_r = XOR over k of coef[(k - r) mod 4] * a_k; byte 0 sits in the MSB.
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_o[AES_COL_W-1-8*r -: 8] = col_o[AES_COL_W-1-8*r -: 8]
          ^ gf_mul_const(col_i[AES_COL_W-1-8*k -: 8],
                         coef_row[AES_COL_W-1-8*((k - r + 4) % 4) -: 8]);
      end
    end
  end

endmodule

// File: rtl/aes_mixcol_sched.sv
// Column-serial MixColumns scheduler sharing one column unit; optional inverse via AES_MIXCOL_INV_EN.
// Latency: 5 cycles accept-to-out_valid when mixing, 1 cycle on last-round bypass.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module aes_mixcol_sched
  import aes_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] in_state,
  input  logic                      in_last,
`ifdef AES_MIXCOL_INV_EN
  input  logic                      in_inv,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] out_state,
  output logic                      busy
);

  localparam int              ST_W     = NUM_COLS * COL_W;
  localparam int              CNT_W    = $clog2(NUM_COLS);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [ST_W-1:0]  work_q, work_d;
  logic [ST_W-1:0]  out_state_q, out_state_d;
`ifdef AES_MIXCOL_INV_EN
  logic             inv_q, inv_d;
`endif

  logic [COL_W-1:0] col_in;
  logic [COL_W-1:0] col_out;

  // Pick the working column addressed by the column counter.
  always_comb begin
    col_in = work_q[ST_W-1 -: COL_W];
    for (int c = 0; c < NUM_COLS; c++) begin
      if (c == int'(col_cnt_q)) col_in = work_q[ST_W-1-COL_W*c -: COL_W];
    end
  end

  aes_mixcol_col u_col (
    .col_i (col_in),
`ifdef AES_MIXCOL_INV_EN
    .inv   (inv_q),
`endif
    .col_o (col_out)
  );

  // Next-state and handshake outputs; one column is written back per MIX cycle.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    out_state_d = out_state_q;
`ifdef AES_MIXCOL_INV_EN
    inv_d       = inv_q;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d = in_state;
`ifdef AES_MIXCOL_INV_EN
          inv_d  = in_inv;
`endif
          if (in_last) begin
            out_state_d = in_state;
            state_d     = DONE;
          end else begin
            col_cnt_d = '0;
            state_d   = MIX;
          end
        end
      end

      MIX: begin
        busy = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
          if (c == int'(col_cnt_q)) out_state_d[ST_W-1-COL_W*c -: COL_W] = col_out;
        end
        if (col_cnt_q == LAST_COL) begin
          col_cnt_d = '0;
          state_d   = DONE;
        end else begin
          col_cnt_d = col_cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_state = out_state_q;

  // State registers with synchronous active-low clear; any in-flight state is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      work_q      <= '0;
      out_state_q <= '0;
`ifdef AES_MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      out_state_q <= out_state_d;
`ifdef AES_MIXCOL_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_mixcol_sched.sv
// Self-checking bench for aes_mixcol_sched: known vectors, corner sequences, random traffic.
// Reference model is a plain GF(2^8) matrix product with polynomial reduction.
// Outputs are sampled 1 time unit after each rising edge.
module tb_aes_mixcol_sched;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last;
`ifdef AES_MIXCOL_INV_EN
  logic         in_inv;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  aes_mixcol_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_last   (in_last),
`ifdef AES_MIXCOL_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] st;
    bit           last;
    bit           inv;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Whole-state (Inv)MixColumns as a circulant matrix product per column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [31:0]  base;
    logic [127:0] res;
    logic [7:0]   a;
    logic [7:0]   cf;
    base = inv ? 32'h0e0b0d09 : 32'h02030101;
    res  = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          a  = s[127-32*c-8*k -: 8];
          cf = base[31-8*((k - r + 4) % 4) -: 8];
          res[127-32*c-8*r -: 8] = res[127-32*c-8*r -: 8] ^ gmul(cf, a);
        end
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE: accept, wait for out_valid, optionally stall, then drain.
  task automatic do_txn(input string name, input logic [127:0] st, input bit last,
                        input bit inv, input logic [127:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    in_state  = st;
    in_last   = last;
`ifdef AES_MIXCOL_INV_EN
    in_inv    = inv;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    chk({name, "_in_ready_idle"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    in_state = ~st;            // must not disturb the captured state
    in_last  = ~last;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk({name, "_in_ready_busy"}, 128'({in_ready, busy}), 128'(2'b01));
      tick();
      lat++;
    end
    chk({name, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({name, "_data"}, out_state, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({name, "_hold"}, {out_state[126:0], out_valid}, {exp[126:0], 1'b1});
    end
    out_ready = 1'b1;
    tick();
    chk({name, "_drain"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    in_last = 1'b0;
    inv = inv;
  endtask

  vec_t vt[7];
  logic [127:0] x1, x2, rs, ex;
  logic [127:0] q_in[3];
  logic [127:0] exp_q[$];
  int           acc_cyc[$];
  int           lat, idx, nout;
  bit           acc, lst, inv_r;

  initial begin
    vt[0] = '{128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0,
              128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 5};
    vt[1] = '{128'hdb135345_f20a225c_01010101_2d26314c, 1'b1, 1'b0,
              128'hdb135345_f20a225c_01010101_2d26314c, 1};
    vt[2] = '{128'hd4d4d4d5_c6c6c6c6_2d26314c_db135345, 1'b0, 1'b0,
              128'hd5d5d7d6_c6c6c6c6_4d7ebdf8_8e4da1bc, 5};
    vt[3] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
              128'h046681e5_e0cb199a_48f8d37a_2806264c, 5};
    vt[4] = '{128'h0, 1'b0, 1'b0, 128'h0, 5};
    vt[5] = '{{4{32'hffffffff}}, 1'b0, 1'b0, {4{32'hffffffff}}, 5};
    vt[6] = '{128'h00000000_11111111_0badcafe_12345678, 1'b1, 1'b0,
              128'h00000000_11111111_0badcafe_12345678, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_last   = 1'b0;
`ifdef AES_MIXCOL_INV_EN
    in_inv    = 1'b0;
`endif
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_ctl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset_out_state", out_state, 128'h0);
    rst_n = 1'b1;
    tick();

    // Table of known vectors.
    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vt[i].st, vt[i].last, vt[i].inv, vt[i].exp, vt[i].lat, 0);

`ifdef AES_MIXCOL_INV_EN
    do_txn("inverse", 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0, 1'b1,
           128'hdb135345_f20a225c_01010101_2d26314c, 5, 0);
`endif

    // Backpressure: result held 10 extra cycles while a new state waits.
    x1 = 128'hdb135345_f20a225c_01010101_2d26314c;
    x2 = {$urandom, $urandom, $urandom, $urandom};
    in_state  = x1;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_state = x2;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'(5));
    chk("bp_first_data", out_state, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    for (int h = 0; h < 10; h++) begin
      tick();
      chk("bp_stable", out_state, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      chk("bp_ctl", 128'({out_valid, in_ready}), 128'(2'b10));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", 128'({out_valid, in_ready}), 128'(2'b01));
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", 128'({busy, in_ready}), 128'(2'b10));
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_second_latency", 128'(lat), 128'(5));
    chk("bp_second_data", out_state, ref_mix(x2, 1'b0));
    tick();

    // Reset on the third MIX cycle.
    in_state = x1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_ctl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    chk("midrst_out_state", out_state, 128'h0);
    rst_n = 1'b1;
    do_txn("post_reset", x1, 1'b0, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 5, 0);

    // Back-to-back: three states, in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) q_in[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0;
    nout = 0;
    out_ready = 1'b1;
    in_last   = 1'b0;
    in_state  = q_in[0];
    in_valid  = 1'b1;
    for (int t = 0; t < 60 && (idx < 3 || exp_q.size() > 0); t++) begin
      if (out_valid) begin
        nout++;
        if (exp_q.size() > 0) chk("b2b_data", out_state, exp_q.pop_front());
        else chk("b2b_unexpected_out", 128'(1), 128'(0));
      end
      acc = in_valid && in_ready;
      if (acc) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(ref_mix(q_in[idx], 1'b0));
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_state = q_in[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_outputs", 128'(nout), 128'(3));
    chk("b2b_accepts", 128'(acc_cyc.size()), 128'(3));
    if (acc_cyc.size() == 3) begin
      chk("b2b_spacing01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
      chk("b2b_spacing12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(6));
    end
    tick();

    // Random traffic with random stalls against the reference model.
    for (int i = 0; i < 24; i++) begin
      rs    = {$urandom, $urandom, $urandom, $urandom};
      lst   = ($urandom_range(0, 3) == 0);
`ifdef AES_MIXCOL_INV_EN
      inv_r = 1'($urandom_range(0, 1));
`else
      inv_r = 1'b0;
`endif
      ex = lst ? rs : ref_mix(rs, inv_r);
      do_txn($sformatf("rand%0d", i), rs, lst, inv_r, ex, lst ? 1 : 5, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_mixcol_sched.md
Name: aes_mixcol_sched

Overview:
Column-serial scheduler that shares one 32-bit single-column MixColumns unit across the four columns of a 128-bit AES state. It accepts a state over a valid/ready handshake and sequences the four columns through the shared unit over four cycles. It then holds the mixed state until the downstream consumer takes it. It sits between SubBytes/ShiftRows and AddRoundKey in an area-reduced AES round datapath; a last-round flag bypasses mixing.

Parameters:
- NUM_COLS, 4, columns per state; fixed for AES, used for counter sizing only.
- COL_W, 32, bits per column.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, in_state/in_last valid.
- in_ready, output, 1, scheduler can accept a state.
- in_state, input, 128, state to mix; column c = in_state[127-32c -: 32], byte 0 of each column in the MSB.
- in_last, input, 1, final round: bypass MixColumns.
- out_valid, output, 1, out_state valid.
- out_ready, input, 1, consumer accepts out_state.
- out_state, output, 128, mixed (or bypassed) state, same column packing as in_state.
- busy, output, 1, high in MIX or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on rst_n. All outputs and registers are cleared on any rising edge with rst_n=0.
- Reset values: FSM=IDLE, col_cnt=0, out_state=0, out_valid=0, busy=0. in_ready=1 after reset.
- FSM states: IDLE, MIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_state into work_reg.
  - If in_last=0: go to MIX with col_cnt=0.
  - If in_last=1: copy in_state to out_state and go to DONE.
- MIX:
  - in_ready=0.
  - Each cycle, column col_cnt of work_reg goes through the single-column unit.
  - The result is written into the same column of out_state.
  - col_cnt increments. When col_cnt==3, col_cnt wraps to 0 and the FSM goes to DONE.
- DONE:
  - out_valid=1. out_state is stable and in_ready=0.
  - On out_ready, go to IDLE and deassert out_valid next cycle.
  - With out_ready low, hold indefinitely.
- Latency, mix path: accept edge at cycle 0, MIX on cycles 1-4, out_valid=1 from cycle 5.
- Latency, bypass path: out_valid=1 from cycle 1.
- Throughput: at most one state per 6 cycles (mix) or 2 cycles (bypass), given out_ready=1.
- Arithmetic:
  - b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 3x = xtime(x)^x. All operations are 8-bit XOR; there are no carries.
- in_valid while not in IDLE: ignored (in_ready=0); the input must be held by the producer.
- in_state and in_last are sampled only at the accept edge; later changes have no effect.
- Reset mid-MIX or mid-DONE: the in-flight state is discarded, the FSM returns to IDLE, and no partial out_valid is produced.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro AES_MIXCOL_INV_EN.
- Defined:
  - Adds input port in_inv (1 bit), sampled at accept alongside in_last.
  - When in_inv=1, the column unit computes InvMixColumns with coefficients {0E,0B,0D,09}, rotated per row as in FIPS-197.
  - Cycle timing is identical to the forward path.
  - in_last=1 still bypasses.
- Undefined:
  - The port is absent and only the forward transform is built.

Decomposition:
- Package aes_pkg:
  - constants AES_STATE_W=128, AES_COL_W=32, AES_POLY=8'h1B.
  - FSM enum typedef sched_state_t {IDLE, MIX, DONE}.
  - functions xtime and gf_mul_const.
- Sub-module aes_mixcol_col: combinational 32-bit single-column MixColumns. It has an inv input under AES_MIXCOL_INV_EN. It is instantiated once and shared by the scheduler.

Test Plan:
- FIPS vector:
  - Stimulus: in_state=db135345_f20a225c_01010101_2d26314c, in_last=0, out_ready=1.
  - Response: out_valid at cycle 5, out_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_ready low on cycles 1-5.
- Bypass:
  - Stimulus: same in_state with in_last=1.
  - Response: out_valid at cycle 1, out_state equals in_state.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid held high and new data presented.
  - Response: out_state stable; in_ready=0 throughout; the second state is accepted only the cycle after out_ready=1 returns.
- Reset mid-operation:
  - Stimulus: rst_n=0 on cycle 3 of MIX.
  - Response: next cycle out_valid=0, busy=0, in_ready=1, out_state=0; a subsequent vector produces a correct result.
- Back-to-back:
  - Stimulus: three states with in_valid and out_ready always high.
  - Response: accepts spaced 6 cycles apart; each output matches the reference model.
- Inverse (AES_MIXCOL_INV_EN):
  - Stimulus: in_inv=1, in_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - Response: out_state=db135345_f20a225c_01010101_2d26314c at cycle 5.
